// File: rtl/mtl2_key_pio_db_if.sv
// Avalon-MM slave bus for the key/switch PIO.
//   address    : register word address
//   chipselect : slave select
//   write_n    : active-low write strobe
//   writedata  : write data
//   readdata   : registered read data (1-cycle latency)
interface mtl2_key_pio_db_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );
endinterface

// File: rtl/mtl2_key_pio_db.sv
// Debounced push-button / switch PIO with edge capture and level IRQ.
//   clk      : system clock
//   reset_n  : asynchronous active-low reset
//   bus      : Avalon-MM slave (address, chipselect, write_n, writedata, readdata)
//   in_port  : raw asynchronous inputs, WIDTH channels
//   irq      : level interrupt, |(EDGE_CAPTURE & IRQ_MASK)
// Register map: 0 DATA, 1 RAW, 2 IRQ_MASK, 3 EDGE_CAPTURE (W1C), 4 RISE_EN, 5 FALL_EN.
module mtl2_key_pio_db #(
  parameter int unsigned WIDTH           = 4,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned IDLE_LEVEL      = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  mtl2_key_pio_db_if.slave     bus,
  input  logic [WIDTH-1:0]     in_port,
  output logic                 irq
);

  localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0]    CNT_MAX  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [WIDTH-1:0] IDLE_VEC = {WIDTH{1'(IDLE_LEVEL)}};

  localparam logic [2:0] A_DATA = 3'd0;
  localparam logic [2:0] A_RAW  = 3'd1;
  localparam logic [2:0] A_MASK = 3'd2;
  localparam logic [2:0] A_CAP  = 3'd3;
  localparam logic [2:0] A_RISE = 3'd4;
  localparam logic [2:0] A_FALL = 3'd5;

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] sync_out;
  logic [WIDTH-1:0] db_q, db_d;
  logic [CW-1:0]    cnt_q [WIDTH];
  logic [CW-1:0]    cnt_d [WIDTH];
  logic [WIDTH-1:0] rise_ev_q, rise_ev_d;
  logic [WIDTH-1:0] fall_ev_q, fall_ev_d;
  logic [WIDTH-1:0] mask_q, rise_en_q, fall_en_q, cap_q;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] clr;
  logic             wr;

  assign wr       = bus.chipselect & ~bus.write_n;
  assign wdata    = bus.writedata[WIDTH-1:0];
  assign sync_out = sync_q[SYNC_STAGES-1];
  assign clr      = (wr && bus.address == A_CAP) ? wdata : '0;

  generate
    if (WIDTH < 32) begin : g_wd_unused
      logic unused_writedata;
      assign unused_writedata = ^bus.writedata[31:WIDTH];
    end
  endgenerate

  // Synchroniser chain per channel
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int s = 0; s < int'(SYNC_STAGES); s++) sync_q[s] <= IDLE_VEC;
    end else begin
      sync_q[0] <= in_port;
      for (int s = 1; s < int'(SYNC_STAGES); s++) sync_q[s] <= sync_q[s-1];
    end
  end

  // Debounce next-state; an edge event is flagged on the edge the level is accepted
  always_comb begin
    db_d      = db_q;
    rise_ev_d = '0;
    fall_ev_d = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      cnt_d[i] = cnt_q[i];
      if (sync_out[i] == db_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_MAX) begin
        db_d[i]      = sync_out[i];
        cnt_d[i]     = '0;
        rise_ev_d[i] = sync_out[i] & rise_en_q[i];
        fall_ev_d[i] = ~sync_out[i] & fall_en_q[i];
      end else begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end
    end
  end

  // Debounce state and event registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      db_q      <= IDLE_VEC;
      rise_ev_q <= '0;
      fall_ev_q <= '0;
      for (int i = 0; i < int'(WIDTH); i++) cnt_q[i] <= '0;
    end else begin
      db_q      <= db_d;
      rise_ev_q <= rise_ev_d;
      fall_ev_q <= fall_ev_d;
      for (int i = 0; i < int'(WIDTH); i++) cnt_q[i] <= cnt_d[i];
    end
  end

  // Control registers; capture set has priority over write-1-to-clear
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mask_q    <= '0;
      rise_en_q <= '0;
      fall_en_q <= '0;
      cap_q     <= '0;
    end else begin
      if (wr && bus.address == A_MASK) mask_q    <= wdata;
      if (wr && bus.address == A_RISE) rise_en_q <= wdata;
      if (wr && bus.address == A_FALL) fall_en_q <= wdata;
      cap_q <= (cap_q & ~clr) | rise_ev_q | fall_ev_q;
    end
  end

  // Read mux, registered every cycle regardless of chipselect
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.readdata <= '0;
    end else begin
      case (bus.address)
        A_DATA:  bus.readdata <= 32'(db_q);
        A_RAW:   bus.readdata <= 32'(sync_out);
        A_MASK:  bus.readdata <= 32'(mask_q);
        A_CAP:   bus.readdata <= 32'(cap_q);
        A_RISE:  bus.readdata <= 32'(rise_en_q);
        A_FALL:  bus.readdata <= 32'(fall_en_q);
        default: bus.readdata <= '0;
      endcase
    end
  end

  // Pure AND-OR of flop outputs
  assign irq = |(cap_q & mask_q);

endmodule

// File: tb/tb_mtl2_key_pio_db.sv
// Directed bench for mtl2_key_pio_db with WIDTH=4, SYNC_STAGES=2, DEBOUNCE_CYCLES=8.
module tb_mtl2_key_pio_db;

  localparam int unsigned WIDTH = 4;

  logic             clk;
  logic             reset_n;
  logic [WIDTH-1:0] in_port;
  logic             irq;

  mtl2_key_pio_db_if bus_if ();

  mtl2_key_pio_db #(
    .WIDTH(4),
    .SYNC_STAGES(2),
    .DEBOUNCE_CYCLES(8),
    .IDLE_LEVEL(1)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus_if.slave),
    .in_port(in_port),
    .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic        is_wr;
    logic        cs;
    logic [2:0]  addr;
    logic [31:0] data;   // write data, or expected read data
    string       name;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // All bus tasks start and end just after a falling edge
  task automatic wr(input logic [2:0] a, input logic [31:0] d, input logic cs = 1'b1);
    bus_if.address    = a;
    bus_if.writedata  = d;
    bus_if.chipselect = cs;
    bus_if.write_n    = 1'b0;
    @(negedge clk);
    bus_if.chipselect = 1'b0;
    bus_if.write_n    = 1'b1;
  endtask

  task automatic rd_check(input string name, input logic [2:0] a, input logic [31:0] exp);
    bus_if.address = a;
    @(negedge clk);
    check(name, bus_if.readdata, exp);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    reset_n           = 1'b0;
    in_port           = 4'hF;
    bus_if.address    = 3'd0;
    bus_if.chipselect = 1'b0;
    bus_if.write_n    = 1'b1;
    bus_if.writedata  = '0;

    // Register access vectors, no input activity
    vecs.push_back('{0, 1, 3'd0, 32'h0000000F, "rst_data"});
    vecs.push_back('{0, 1, 3'd1, 32'h0000000F, "rst_raw"});
    vecs.push_back('{0, 1, 3'd3, 32'h00000000, "rst_cap"});
    vecs.push_back('{0, 1, 3'd2, 32'h00000000, "rst_mask"});
    vecs.push_back('{1, 0, 3'd2, 32'h0000000F, "wr_no_cs"});
    vecs.push_back('{0, 1, 3'd2, 32'h00000000, "mask_no_cs"});
    vecs.push_back('{1, 1, 3'd2, 32'hFFFFFFFF, "wr_mask"});
    vecs.push_back('{0, 1, 3'd2, 32'h0000000F, "mask_upper0"});
    vecs.push_back('{1, 1, 3'd4, 32'h000000A5, "wr_rise"});
    vecs.push_back('{0, 1, 3'd4, 32'h00000005, "rise_rb"});
    vecs.push_back('{1, 1, 3'd5, 32'h0000003C, "wr_fall"});
    vecs.push_back('{0, 1, 3'd5, 32'h0000000C, "fall_rb"});
    vecs.push_back('{1, 1, 3'd6, 32'h000000FF, "wr_addr6"});
    vecs.push_back('{0, 1, 3'd6, 32'h00000000, "addr6"});
    vecs.push_back('{0, 1, 3'd7, 32'h00000000, "addr7"});
    vecs.push_back('{1, 1, 3'd3, 32'h0000000F, "wr_cap"});
    vecs.push_back('{0, 1, 3'd3, 32'h00000000, "cap_ro"});
    vecs.push_back('{1, 1, 3'd2, 32'h00000000, "clr_mask"});
    vecs.push_back('{1, 1, 3'd4, 32'h00000000, "clr_rise"});
    vecs.push_back('{1, 1, 3'd5, 32'h00000000, "clr_fall"});
    vecs.push_back('{0, 1, 3'd5, 32'h00000000, "fall_zero"});

    // Reset state
    #12;
    check("rst_readdata", bus_if.readdata, 32'h0);
    check("rst_irq", 32'(irq), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    idle(2);

    foreach (vecs[k]) begin
      if (vecs[k].is_wr) wr(vecs[k].addr, vecs[k].data, vecs[k].cs);
      else rd_check(vecs[k].name, vecs[k].addr, vecs[k].data);
    end
    check("tbl_irq", 32'(irq), 32'h0);

    // Exact fall latency on channel 0: capture on the 11th edge after the change
    wr(3'd5, 32'h1);
    wr(3'd2, 32'h1);
    bus_if.address = 3'd3;
    in_port[0] = 1'b0;
    idle(10);
    check("lat_irq_e10", 32'(irq), 32'h0);
    idle(1);
    check("lat_irq_e11", 32'(irq), 32'h1);
    check("lat_rd_e11", bus_if.readdata, 32'h0);
    idle(1);
    check("lat_rd_e12", bus_if.readdata, 32'h1);
    rd_check("lat_data", 3'd0, 32'hE);
    wr(3'd3, 32'h1);
    rd_check("lat_clr", 3'd3, 32'h0);
    check("lat_clr_irq", 32'(irq), 32'h0);
    in_port[0] = 1'b1;
    idle(14);
    rd_check("lat_rise_off", 3'd3, 32'h0);
    rd_check("lat_data_back", 3'd0, 32'hF);

    // Glitch shorter than the debounce window is rejected
    wr(3'd5, 32'hF);
    wr(3'd2, 32'hF);
    in_port[1] = 1'b0;
    idle(7);
    in_port[1] = 1'b1;
    idle(14);
    rd_check("glitch7_data", 3'd0, 32'hF);
    rd_check("glitch7_cap", 3'd3, 32'h0);
    check("glitch7_irq", 32'(irq), 32'h0);

    // Pulse of exactly the debounce window is accepted
    in_port[1] = 1'b0;
    idle(8);
    in_port[1] = 1'b1;
    idle(20);
    rd_check("pulse8_cap", 3'd3, 32'h2);
    rd_check("pulse8_data", 3'd0, 32'hF);
    wr(3'd3, 32'h2);
    rd_check("pulse8_clr", 3'd3, 32'h0);

    // Bounce low 5 / high 2 / low held: count restarts from the last change
    in_port[1] = 1'b0;
    idle(5);
    in_port[1] = 1'b1;
    idle(2);
    in_port[1] = 1'b0;
    idle(10);
    check("bounce_irq_e10", 32'(irq), 32'h0);
    idle(1);
    check("bounce_irq_e11", 32'(irq), 32'h1);

    // Write-1-to-clear with EDGE_CAPTURE=0x3
    in_port[0] = 1'b0;
    idle(14);
    rd_check("cap3", 3'd3, 32'h3);
    wr(3'd3, 32'h0);
    rd_check("w0_keeps", 3'd3, 32'h3);
    wr(3'd3, 32'h1);
    rd_check("w1c_bit0", 3'd3, 32'h2);

    // Clear on the same edge a new channel-1 event sets: set wins
    wr(3'd4, 32'h2);
    in_port[1] = 1'b1;
    idle(10);
    wr(3'd3, 32'h2);
    rd_check("set_wins", 3'd3, 32'h2);
    wr(3'd3, 32'h2);
    rd_check("set_wins_clr", 3'd3, 32'h0);
    in_port[0] = 1'b1;
    idle(14);
    rd_check("rise0_off", 3'd3, 32'h0);
    wr(3'd4, 32'h0);
    wr(3'd5, 32'h0);
    wr(3'd2, 32'h0);

    // Channel 2 both edges, masked then unmasked
    wr(3'd4, 32'h4);
    wr(3'd5, 32'h4);
    in_port[2] = 1'b0;
    idle(14);
    rd_check("ch2_fall_cap", 3'd3, 32'h4);
    check("ch2_masked_irq", 32'(irq), 32'h0);
    wr(3'd2, 32'h4);
    check("ch2_unmask_irq", 32'(irq), 32'h1);
    wr(3'd3, 32'h4);
    check("ch2_clr_irq", 32'(irq), 32'h0);
    rd_check("ch2_clr_cap", 3'd3, 32'h0);
    in_port[2] = 1'b1;
    idle(14);
    rd_check("ch2_rise_cap", 3'd3, 32'h4);
    check("ch2_rise_irq", 32'(irq), 32'h1);
    wr(3'd4, 32'h0);
    wr(3'd5, 32'h0);
    rd_check("en_change_keeps", 3'd3, 32'h4);
    wr(3'd3, 32'h4);
    wr(3'd2, 32'h0);

    // Reset mid-count on channel 3
    wr(3'd5, 32'h8);
    in_port[3] = 1'b0;
    idle(6);
    reset_n = 1'b0;
    #1;
    check("mid_rst_readdata", bus_if.readdata, 32'h0);
    check("mid_rst_irq", 32'(irq), 32'h0);
    idle(2);
    bus_if.address = 3'd0;
    reset_n = 1'b1;
    idle(10);
    check("restart_e10", bus_if.readdata, 32'hF);
    idle(1);
    check("restart_e11", bus_if.readdata, 32'h7);
    rd_check("restart_cap", 3'd3, 32'h0);
    rd_check("restart_fall_en", 3'd5, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mtl2_key_pio_db.md
Name: mtl2_key_pio_db

Overview:
- Parametrised successor of the MTL2 push-button PIO: Avalon-MM slave, WIDTH input channels.
- Per-channel synchroniser, counter-based debouncer and independently enabled rising/falling edge capture.
- Per-bit write-1-to-clear capture register; level IRQ to the Nios II interrupt controller.
- Sits between the board keys/switches and the system interconnect in the MTL2 painter system.

Parameters:
- WIDTH, 4, number of input channels (1..32).
- SYNC_STAGES, 2, synchroniser flops per channel (2..4).
- DEBOUNCE_CYCLES, 50000, consecutive stable clk cycles required to accept a new level (>=1).
- IDLE_LEVEL, 1, reset value of synchroniser and debounced registers for every channel (0 or 1); keys are active-low.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  reset; asynchronous, active-low.
- address  in  3  register word address.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data.
- in_port  in  WIDTH  raw asynchronous inputs.
- readdata  out  32  registered read data.
- irq  out  1  level interrupt.

Behaviour:
- Register map (unused upper bits read 0, writes ignored):
  - 0 DATA RO: debounced levels.
  - 1 RAW RO: synchronised levels.
  - 2 IRQ_MASK RW.
  - 3 EDGE_CAPTURE: RO, write-1-to-clear per bit.
  - 4 RISE_EN RW.
  - 5 FALL_EN RW.
  - 6, 7 read 0.
- Reset: readdata=0; irq=0; IRQ_MASK, EDGE_CAPTURE, RISE_EN, FALL_EN = 0; all debounce counters = 0; sync and debounced regs = {WIDTH{IDLE_LEVEL}}.
- readdata: registered every clk from address (independent of chipselect); read latency 1 cycle.
- Writes: take effect at the clk edge when chipselect && !write_n.
- Synchroniser: in_port change seen at sync output SYNC_STAGES edges later.
- Debouncer, per channel; the counter width holds DEBOUNCE_CYCLES-1:
  - sync == debounced: counter := 0.
  - sync != debounced and counter == DEBOUNCE_CYCLES-1: debounced := sync; counter := 0.
  - Otherwise: counter += 1.
  - A glitch shorter than DEBOUNCE_CYCLES cycles never reaches DATA. Any return to the debounced level restarts the count.
  - DEBOUNCE_CYCLES=1: debounced follows sync with one cycle of delay.
- Edge events:
  - rise[i] = debounced 0->1 && RISE_EN[i].
  - fall[i] = debounced 1->0 && FALL_EN[i].
  - Both are evaluated on the edge where debounced updates; EDGE_CAPTURE[i] sets on the following edge.
  - Total latency in_port -> EDGE_CAPTURE = SYNC_STAGES + DEBOUNCE_CYCLES + 1 edges.
- EDGE_CAPTURE bit stays set until software writes 1 to it. Writing 0 leaves the bit unchanged.
- Simultaneous write-1-clear and new event on the same bit: set wins (no lost event). Other bits are unaffected.
- Changing RISE_EN/FALL_EN does not alter already-captured bits.
- irq = |(EDGE_CAPTURE & IRQ_MASK), combinational from registers, glitch-free. Unmasking a pending bit asserts irq the cycle after the IRQ_MASK write.
- Asynchronous reset mid-debounce: counters are discarded and channels return to IDLE_LEVEL. No event is generated by reset itself.
- No other state machines.

Test Plan:
- Reset, IDLE_LEVEL=1, WIDTH=4 -> read addr 0 returns 0xF, addr 3 returns 0x0, irq=0.
- DEBOUNCE_CYCLES=8:
  - RISE_EN=0, FALL_EN=1, IRQ_MASK=1; drive in_port[0] 1->0 and hold -> EDGE_CAPTURE=0x1 exactly SYNC_STAGES+9 edges after the change; irq=1.
  - Pulse in_port[1] low for 7 cycles -> DATA, RAW-derived capture unchanged; EDGE_CAPTURE=0.
  - Bounce in_port[1] low 5 / high 2 / low held -> capture only after 8 stable cycles.
- With EDGE_CAPTURE=0x3: write 0x1 to addr 3 -> reads 0x2. Write 0x2 in the same cycle a new channel-1 event sets it -> bit 1 remains 1.
- RISE_EN=FALL_EN=0x4; toggle in_port[2] 1->0->1 (each held) -> two captures, each cleared in between. IRQ_MASK=0 keeps irq=0 while EDGE_CAPTURE=0x4; then writing IRQ_MASK=0x4 -> irq=1 next cycle.
- Assert reset_n low while a channel counter is mid-count -> after release, DATA=IDLE pattern, no capture, counters restart from 0.
